// File: rtl/addsub_pkg.sv
// Shared types and helpers for the round-robin arbitrated add/sub unit.
// No ports; provides default sizing, the operation payload struct and
// the round-robin pointer successor function.
package addsub_pkg;

  localparam int unsigned ADDSUB_N   = 4;
  localparam int unsigned ADDSUB_R   = 4;
  localparam int unsigned ADDSUB_IDW = $clog2(ADDSUB_R);

  // One queued operation at the default sizing.
  typedef struct packed {
    logic [ADDSUB_N-1:0]   a;
    logic [ADDSUB_N-1:0]   b;
    logic                  sub;
    logic [ADDSUB_IDW-1:0] id;
  } addsub_op_t;

  // Pointer value after 'winner' has been served: one past it, wrapping at num_req.
  function automatic int unsigned rr_next(input int unsigned winner,
                                          input int unsigned num_req);
    int unsigned nxt;
    nxt = winner + 1;
    if (nxt >= num_req) nxt = 0;
    return nxt;
  endfunction

endpackage

// File: rtl/adder_subtractor.sv
// Ripple-carry adder/subtractor, purely combinational.
// Ports: a, b (N-bit operands), sub (1 = a-b), sum_c (N-bit result mod 2^N),
//        cout_c (carry out; on subtraction 1 means no borrow).
module adder_subtractor #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum_c,
  output logic         cout_c
);

  logic [N-1:0] b_x;
  logic [N:0]   carry;

  // Subtraction is a + ~b + 1, the +1 entering as carry-in.
  always_comb begin
    b_x      = b ^ {N{sub}};
    carry    = '0;
    sum_c    = '0;
    carry[0] = sub;
    for (int i = 0; i < int'(N); i++) begin
      sum_c[i]   = a[i] ^ b_x[i] ^ carry[i];
      carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
    end
    cout_c = carry[N];
  end

endmodule

// File: rtl/rr_arbiter.sv
// R-wide round-robin arbiter with a one-hot grant.
// Ports: clk, rst (async active-high), req (R requests), advance (commit the
//        current winner and move the pointer past it), grant_c (one-hot or
//        zero), winner_c (index of the granted requester).
module rr_arbiter
  import addsub_pkg::*;
#(
  parameter  int unsigned R   = 4,
  localparam int unsigned IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic           advance,
  output logic [R-1:0]   grant_c,
  output logic [IDW-1:0] winner_c
);

  logic [IDW-1:0] ptr;
  logic [IDW:0]   pos;
  logic [IDW-1:0] idx;
  logic           found;

  // First asserted request scanning upward from ptr, wrapping at R.
  always_comb begin
    grant_c  = '0;
    winner_c = '0;
    found    = 1'b0;
    pos      = '0;
    idx      = '0;
    for (int k = 0; k < int'(R); k++) begin
      pos = {1'b0, ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(R)) pos = pos - (IDW+1)'(R);
      idx = IDW'(pos);
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        winner_c     = idx;
      end
    end
  end

  // Pointer moves only when the grant is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IDW'(rr_next(32'(winner_c), R));
    end
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin sharing of one adder_subtractor among R requesters through a
// two-stage pipeline (operand register, result register) with valid/ready on
// both sides and full backpressure.
// Ports: clk, rst (async active-high); req_valid/req_ready/req_a/req_b/req_sub
//        (per-requester request side, operands packed at [i*N +: N]);
//        rsp_valid/rsp_ready/rsp_sum/rsp_cout/rsp_id (response side).
// req_ready is combinational on req_valid and the pipeline state.
module addsub_rr_arbiter
  import addsub_pkg::*;
#(
  parameter  int unsigned N   = ADDSUB_N,
  parameter  int unsigned R   = ADDSUB_R,
  localparam int unsigned IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*N-1:0]   req_a,
  input  logic [R*N-1:0]   req_b,
  input  logic [R-1:0]     req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_sum,
  output logic             rsp_cout,
  output logic [IDW-1:0]   rsp_id
);

  logic [R-1:0]   grant;
  logic [IDW-1:0] winner;
  logic           s1_free;
  logic           s2_free;
  logic           accept;

  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           sel_sub;

  logic           op_valid;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           op_sub;
  logic [IDW-1:0] op_id;

  logic [N-1:0]   alu_sum;
  logic           alu_cout;

  assign s2_free   = !rsp_valid || rsp_ready;
  assign s1_free   = !op_valid || s2_free;
  // Gated by rst so no request is acknowledged while the pipeline is held in reset.
  assign req_ready = grant & {R{s1_free}} & {R{!rst}};
  assign accept    = |req_ready;

  rr_arbiter #(.R(R)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .advance  (accept),
    .grant_c  (grant),
    .winner_c (winner)
  );

  // Operand mux for the current winner.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < int'(R); i++) begin
      if (winner == IDW'(i)) begin
        sel_a   = req_a[i*N +: N];
        sel_b   = req_b[i*N +: N];
        sel_sub = req_sub[i];
      end
    end
  end

  // Stage 1: operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      op_id    <= '0;
    end else if (accept) begin
      op_valid <= 1'b1;
      op_a     <= sel_a;
      op_b     <= sel_b;
      op_sub   <= sel_sub;
      op_id    <= winner;
    end else if (s1_free) begin
      op_valid <= 1'b0;
    end
  end

  adder_subtractor #(.N(N)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .sub    (op_sub),
    .sum_c  (alu_sum),
    .cout_c (alu_cout)
  );

  // Stage 2: result register, drives the response port directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else if (op_valid && s2_free) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= alu_sum;
      rsp_cout  <= alu_cout;
      rsp_id    <= op_id;
    end else if (s2_free) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed self-checking bench for addsub_rr_arbiter (N=4, R=4).
module tb_addsub_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned R = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_sub;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     rsp_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_rr_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  // Requester i: a=i+1, b=2i, add -> sums 1,4,7,10.
  task automatic set_fair_ops();
    for (int i = 0; i < int'(R); i++) begin
      req_a[i*N +: N] = 4'(i + 1);
      req_b[i*N +: N] = 4'(2 * i);
    end
    req_sub = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0; req_valid = 4'b1011;
    set_fair_ops();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_sum !== 4'h0) begin errors++; $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp_cout got=%b exp=0", rsp_cout); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    rst = 1'b0; req_valid = 4'b0110; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_first_grant got=%b exp=0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 4'd4) begin
      errors++; $display("FAIL reset_first_rsp got=v%b id%0d sum%0d exp=v1 id1 sum4", rsp_valid, rsp_id, rsp_sum);
    end
  endtask

  task automatic test_single_add();
    @(negedge clk);
    req_a[8 +: 4] = 4'd5; req_b[8 +: 4] = 4'd3; req_sub[2] = 1'b0;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL add_req_ready got=%b exp=0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_latency_early got=%b exp=0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_sum !== 4'd8) begin errors++; $display("FAIL add_rsp_sum got=%0d exp=8", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL add_rsp_cout got=%b exp=0", rsp_cout); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL add_rsp_id got=%0d exp=2", rsp_id); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_consumed got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_sub();
    logic [3:0] ta [3] = '{4'd3, 4'd5, 4'd15};
    logic [3:0] tb [3] = '{4'd5, 4'd3, 4'd1};
    logic       ts [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] es [3] = '{4'hE, 4'h2, 4'h0};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      req_a[4 +: 4] = ta[v]; req_b[4 +: 4] = tb[v]; req_sub[1] = ts[v];
      req_valid = 4'b0010;
      @(posedge clk); #1 req_valid = '0;
      repeat (2) @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
        errors++; $display("FAIL sub%0d_valid_id got=v%b id%0d exp=v1 id1", v, rsp_valid, rsp_id);
      end
      checks++; if (rsp_sum !== es[v]) begin errors++; $display("FAIL sub%0d_sum got=%h exp=%h", v, rsp_sum, es[v]); end
      checks++; if (rsp_cout !== ec[v]) begin errors++; $display("FAIL sub%0d_cout got=%b exp=%b", v, rsp_cout, ec[v]); end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] fs [4] = '{4'd1, 4'd4, 4'd7, 4'd10};
    @(negedge clk);
    rst = 1'b1; #1 rst = 1'b0;
    set_fair_ops();
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin
        errors++; $display("FAIL fair_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
      end
      if (k >= 2) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 2) % 4) || rsp_sum !== fs[(k - 2) % 4]) begin
          errors++; $display("FAIL fair_rsp%0d got=v%b id%0d sum%0d exp=v1 id%0d sum%0d",
                             k, rsp_valid, rsp_id, rsp_sum, (k - 2) % 4, fs[(k - 2) % 4]);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fair_drained got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0; req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got=%b exp=0001", req_ready); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_grant1 got=%b v%b exp=0010 v0", req_ready, rsp_valid);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall%0d_ready got=%b exp=0000", j, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 4'd1) begin
        errors++; $display("FAIL bp_stall%0d_hold got=v%b id%0d sum%0d exp=v1 id0 sum1", j, rsp_valid, rsp_id, rsp_sum);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_resume_grant got=%b exp=0100", req_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 4'd4) begin
      errors++; $display("FAIL bp_drain1 got=v%b id%0d sum%0d exp=v1 id1 sum4", rsp_valid, rsp_id, rsp_sum);
    end
    req_valid = '0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 4'd7) begin
      errors++; $display("FAIL bp_drain2 got=v%b id%0d sum%0d exp=v1 id2 sum7", rsp_valid, rsp_id, rsp_sum);
    end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_midflight_reset();
    rsp_ready = 1'b0; req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mr_grant3 got=%b exp=1000", req_ready); end
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mr_grant0 got=%b exp=0001", req_ready); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 4'd10 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL mr_full got=v%b id%0d sum%0d rdy%b exp=v1 id3 sum10 rdy0000", rsp_valid, rsp_id, rsp_sum, req_ready);
    end
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 4'd0 || rsp_cout !== 1'b0) begin
      errors++; $display("FAIL mr_async_clear got=v%b id%0d sum%0d c%b exp=all 0", rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mr_ready_in_reset got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mr_restart got=%b v%b exp=0001 v0", req_ready, rsp_valid);
    end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL mr_no_stale got=v%b rdy%b exp=v0 rdy0010", rsp_valid, req_ready);
    end
    req_valid = '0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 4'd1) begin
      errors++; $display("FAIL mr_first_rsp got=v%b id%0d sum%0d exp=v1 id0 sum1", rsp_valid, rsp_id, rsp_sum);
    end
  endtask

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_single_add();
    test_sub();
    test_fairness();
    test_backpressure();
    test_midflight_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
